// File: rtl/alu_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Resolves one quotient bit per clock; the latency is fixed for every operand pair.
module alu_div #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_div_a,
    input  logic [WIDTH-1:0] i_div_b,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic [WIDTH-1:0] result_reg;
    logic             is_rem_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             div_zero_reg;

    logic             capture;
    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    logic [WIDTH:0]   shifted;
    logic             take;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] final_value;

    // Requests are honoured only outside RUN; a start during RUN is dropped.
    assign capture   = i_start && (state_reg != RUN);
    assign op_signed = ~i_op[0];
    assign a_neg     = op_signed & i_div_a[WIDTH-1];
    assign b_neg     = op_signed & i_div_b[WIDTH-1];
    assign mag_a     = a_neg ? (~i_div_a + 1'b1) : i_div_a;
    assign mag_b     = b_neg ? (~i_div_b + 1'b1) : i_div_b;

    // Trial subtraction on the shifted partial remainder; the difference always fits WIDTH bits when taken.
    always_comb begin
        shifted  = {rem_reg, quo_reg[WIDTH-1]};
        take     = (shifted >= {1'b0, divisor_reg});
        rem_next = take ? (shifted[WIDTH-1:0] - divisor_reg) : shifted[WIDTH-1:0];
        quo_next = {quo_reg[WIDTH-2:0], take};
    end

    // Divide-by-zero leaves quotient all ones, but the signed fix-up must not flip it.
    always_comb begin
        final_value = '0;
        if (is_rem_reg) begin
            final_value = neg_r_reg ? (~rem_next + 1'b1) : rem_next;
        end else if (div_zero_reg) begin
            final_value = '1;
        end else begin
            final_value = neg_q_reg ? (~quo_next + 1'b1) : quo_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (i_start) state_next = RUN;
            RUN:     if (cnt_reg == '0) state_next = DONE;
            DONE:    state_next = i_start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy   = (state_reg == RUN);
        o_valid  = (state_reg == DONE);
        o_result = result_reg;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_reg      <= '0;
            rem_reg      <= '0;
            quo_reg      <= '0;
            divisor_reg  <= '0;
            result_reg   <= '0;
            is_rem_reg   <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
        end else if (capture) begin
            cnt_reg      <= CW'(WIDTH - 1);
            rem_reg      <= '0;
            quo_reg      <= mag_a;
            divisor_reg  <= mag_b;
            is_rem_reg   <= i_op[1];
            neg_q_reg    <= a_neg ^ b_neg;
            neg_r_reg    <= a_neg;
            div_zero_reg <= (i_div_b == '0);
        end else if (state_reg == RUN) begin
            cnt_reg <= cnt_reg - 1'b1;
            rem_reg <= rem_next;
            quo_reg <= quo_next;
            if (cnt_reg == '0) begin
                result_reg <= final_value;
            end
        end
    end

endmodule

// File: tb/tb_alu_div.sv
// Self-checking bench for alu_div: directed RISC-V corner cases, randomized operands
// against an arithmetic reference model, start-during-RUN, back-to-back and mid-run reset.
module tb_alu_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        valid;
    logic [31:0] result;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    alu_div #(.WIDTH(32)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_op     (op),
        .i_div_a  (a),
        .i_div_b  (b),
        .o_busy   (busy),
        .o_valid  (valid),
        .o_result (result)
    );

    // RISC-V M-extension semantics using the simulator's own integer division.
    function automatic logic [31:0] ref_div(input logic [1:0] f_op, input logic [31:0] fa, input logic [31:0] fb);
        logic [31:0] r;
        if (fb == 32'd0) begin
            r = f_op[1] ? fa : 32'hFFFF_FFFF;
        end else if (!f_op[0] && fa == 32'h8000_0000 && fb == 32'hFFFF_FFFF) begin
            r = f_op[1] ? 32'd0 : 32'h8000_0000;
        end else begin
            case (f_op)
                2'b00:   r = $signed(fa) / $signed(fb);
                2'b01:   r = fa / fb;
                2'b10:   r = $signed(fa) % $signed(fb);
                default: r = fa % fb;
            endcase
        end
        return r;
    endfunction

    // Issues one request at the current negedge; returns at the negedge of the o_valid cycle.
    // lat counts clock edges from the start cycle to the valid cycle (100 means timed out).
    task automatic do_div(input logic [1:0] t_op, input logic [31:0] ta, input logic [31:0] tb_v,
                          output logic [31:0] res, output int lat);
        op = t_op; a = ta; b = tb_v; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        @(negedge clk);
        while (!valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res = result;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if ({busy, valid, result} !== 34'd0) $display("FAIL reset_state: busy=%0b valid=%0b result=%08h, expected all zero", busy, valid, result);
        else pass_cnt++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || valid !== 1'b0) $display("FAIL idle_after_reset: busy=%0b valid=%0b, expected 0 0", busy, valid);
        else pass_cnt++;
        $display("reset: busy=%0b valid=%0b result=%08h", busy, valid, result);
    endtask

    task automatic test_directed();
        logic [1:0]  t_op [14] = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b10, 2'b11,
                                   2'b00, 2'b10, 2'b01, 2'b00, 2'b10};
        logic [31:0] t_a  [14] = '{32'd100, 32'd100, 32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd20,
                                   32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678,
                                   32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [31:0] t_b  [14] = '{32'd7, 32'd7, 32'd3, 32'd3, 32'hFFFF_FFFD,
                                   32'd0, 32'd0, 32'd0, 32'd0,
                                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] t_e  [14] = '{32'd14, 32'd2, 32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'd2,
                                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678,
                                   32'h8000_0000, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 14; i++) begin
            do_div(t_op[i], t_a[i], t_b[i], res, lat);
            $display("directed[%0d]: op=%0d a=%08h b=%08h result=%08h latency=%0d", i, t_op[i], t_a[i], t_b[i], res, lat);
            total_cnt++;
            if (res !== t_e[i]) $display("FAIL directed_result[%0d]: got %08h, expected %08h", i, res, t_e[i]);
            else pass_cnt++;
            total_cnt++;
            if (lat !== 33) $display("FAIL directed_latency[%0d]: got %0d, expected 33", i, lat);
            else pass_cnt++;
            @(negedge clk);
            total_cnt++;
            if (valid !== 1'b0 || busy !== 1'b0 || result !== t_e[i])
                $display("FAIL valid_pulse[%0d]: valid=%0b busy=%0b result=%08h, expected 0 0 %08h", i, valid, busy, result, t_e[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b, res, exp_v;
        int lat;
        for (int i = 0; i < 60; i++) begin
            r_op = 2'($urandom);
            r_a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       r_b = 32'd0;
                1:       r_b = 32'hFFFF_FFFF;
                2:       r_b = $urandom_range(1, 16);
                default: r_b = $urandom >> $urandom_range(0, 31);
            endcase
            exp_v = ref_div(r_op, r_a, r_b);
            do_div(r_op, r_a, r_b, res, lat);
            $display("random[%0d]: op=%0d a=%08h b=%08h result=%08h latency=%0d", i, r_op, r_a, r_b, res, lat);
            total_cnt++;
            if (res !== exp_v || lat !== 33)
                $display("FAIL random[%0d]: result=%08h latency=%0d, expected %08h latency 33", i, res, lat, exp_v);
            else pass_cnt++;
            if (i % 2 == 0) @(negedge clk);
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        op = 2'b01; a = 32'd1000; b = 32'd9; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        op = 2'b00; a = $urandom; b = 32'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 11;
        @(negedge clk);
        while (!valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        $display("ignore_start: result=%08h latency=%0d", result, lat);
        total_cnt++;
        if (result !== 32'd111 || lat !== 33)
            $display("FAIL ignore_start: result=%08h latency=%0d, expected 0000006f latency 33", result, lat);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || valid !== 1'b0) $display("FAIL no_queued_request: busy=%0b valid=%0b, expected 0 0", busy, valid);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] res1, res2;
        int lat1, lat2;
        do_div(2'b11, 32'd12345, 32'd100, res1, lat1);
        do_div(2'b00, 32'hFFFF_FC18, 32'd7, res2, lat2);
        $display("back_to_back: first=%08h (lat %0d) second=%08h (lat %0d)", res1, lat1, res2, lat2);
        total_cnt++;
        if (res1 !== 32'd45 || lat1 !== 33) $display("FAIL b2b_first: result=%08h latency=%0d, expected 0000002d latency 33", res1, lat1);
        else pass_cnt++;
        total_cnt++;
        if (res2 !== 32'hFFFF_FF72 || lat2 !== 33) $display("FAIL b2b_second: result=%08h latency=%0d, expected ffffff72 latency 33", res2, lat2);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] res;
        int lat;
        bit seen;
        op = 2'b01; a = 32'hFFFF_FFFF; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        $display("reset_mid_run: busy=%0b valid=%0b result=%08h", busy, valid, result);
        total_cnt++;
        if (busy !== 1'b0 || valid !== 1'b0 || result !== 32'd0)
            $display("FAIL async_reset: busy=%0b valid=%0b result=%08h, expected 0 0 00000000", busy, valid, result);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid || busy) seen = 1'b1;
        end
        total_cnt++;
        if (seen) $display("FAIL aborted_run: activity after reset release, expected none");
        else pass_cnt++;
        do_div(2'b01, 32'hFFFF_FFFF, 32'd3, res, lat);
        $display("after_reset: result=%08h latency=%0d", res, lat);
        total_cnt++;
        if (res !== 32'h5555_5555 || lat !== 33) $display("FAIL after_reset: result=%08h latency=%0d, expected 55555555 latency 33", res, lat);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alu_div.md
Name: alu_div

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV, DIVU, REM and REMU instructions.
- Sits beside alu_slt in the execute stage. It takes the same A/B operand buses and feeds the ALU result mux / writeback select.
- Control holds the PC and stalls while o_busy is high, then captures o_result when o_valid pulses.
- Fixed latency: one quotient bit resolved per clock.

Parameters:
WIDTH  32  operand/result width; iteration count equals WIDTH

Ports:
i_clk      in   1      clock, rising edge
i_rst_n    in   1      asynchronous reset, active-low
i_start    in   1      request; sampled only in IDLE or DONE
i_op       in   2      00 DIV, 01 DIVU, 10 REM, 11 REMU; captured with i_start
i_div_a    in   WIDTH  dividend; captured with i_start
i_div_b    in   WIDTH  divisor; captured with i_start
o_busy     out  1      high while a division is in progress
o_valid    out  1      one-cycle pulse, o_result holds the final value
o_result   out  WIDTH  quotient or remainder per captured i_op

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - state IDLE; o_busy=0, o_valid=0, o_result=0; all internal registers cleared.
- States: IDLE, RUN, DONE.
- IDLE or DONE, with i_start=1 at edge E0:
  - Latch op, sign flags, |A|, |B| (magnitudes only for signed ops; raw values for DIVU/REMU).
  - Clear partial remainder; load iteration counter = WIDTH-1; go to RUN.
  - o_busy=1 from E0.
- RUN, each edge:
  - Shift {rem, quo} left by 1.
  - Trial subtract: rem - |B| as a WIDTH+1 bit result.
  - If the result is non-negative, rem = difference and the quotient LSB is 1; otherwise rem is restored and the LSB is 0.
  - Counter decrements. On the edge where counter==0, go to DONE.
  - That is edges E1..E32 for WIDTH=32.
- DONE (entered at E32):
  - o_busy=0, o_valid=1 for exactly this one cycle; o_result is written at E32.
  - Next edge: go to IDLE, unless i_start=1, which begins a new RUN back-to-back.
- Latency: i_start sampled at E0 -> o_valid high in the cycle after E32. This is fixed for every case, special cases included.
- Sign fix-up (signed ops only):
  - Quotient is negated when sign(A) != sign(B).
  - Remainder takes the sign of A.
  - Applied when writing o_result.
- Special cases (RISC-V mandated, decided at capture, still 32-cycle latency):
  - B==0: DIV/DIVU give all ones (0xFFFFFFFF); REM/REMU give A unchanged.
  - DIV/REM with A=0x80000000 and B=0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- o_result holds its last value until the next o_valid. It is not cleared on i_start.
- i_start while in RUN is ignored. The operands and op of the in-flight division are unaffected, and no request is queued.
- Reset asserted mid-RUN: the division is aborted immediately; no o_valid is produced after reset release.
- i_op, i_div_a and i_div_b are don't-care outside the capture edge.

Test Plan:
- DIVU A=100, B=7 -> o_valid 33 cycles after start, o_result=14 (0x0000000E); REMU same operands -> 2.
- DIV A=-20 (0xFFFFFFEC), B=3 -> 0xFFFFFFFA (-6); REM same operands -> 0xFFFFFFFE (-2); REM A=20, B=-3 -> 2.
- Divide by zero, A=0x12345678, B=0:
  - DIV and DIVU -> 0xFFFFFFFF; REM and REMU -> 0x12345678.
  - Latency is still 33 cycles.
- Signed overflow, A=0x80000000, B=0xFFFFFFFF: DIV -> 0x80000000, REM -> 0; DIVU same operands -> 0x00000000.
- i_start pulsed with new operands at cycle 10 of RUN -> ignored; the first result is correct. A back-to-back i_start during DONE -> second result 33 cycles later, with no idle gap.
- i_rst_n driven low at cycle 15 of RUN -> o_busy=0, o_valid=0, o_result=0 asynchronously. After release, no o_valid appears and the next start gives the correct result.
